// File: rtl/cart_dram_ctrl.sv
// cart_dram_ctrl
//   A-bus slave controller for an extended-RAM cartridge. CS0 accesses that
//   fall inside the RAM window are sequenced onto a req/ack word-memory port.
//   Reads stall the bus through AWAIT_N until data returns. Writes are posted
//   through a one-deep buffer. CS1 reads at AA[23:0]=24'hFFFFFE return the
//   cartridge ID byte.
//
// Ports
//   CLK, RST           system clock, synchronous active-high reset
//   CE_R               A-bus rising-edge clock enable for strobe sampling
//   AA, ADI, ADO       A-bus byte address, write data, read data
//   ACS0_N, ACS1_N     chip selects (RAM window / ID register), active low
//   ARD_N              read strobe, active low
//   AWRL_N, AWRU_N     low/high byte write strobes, active low
//   AWAIT_N            bus wait, active low
//   MEM_A/D/BE/WE      memory word address, write data, byte enables, direction
//   MEM_REQ, MEM_ACK   request (held until ack), one-cycle acknowledge
//   MEM_Q              memory read data, valid with MEM_ACK
//   ERR                sticky memory timeout flag
module cart_dram_ctrl #(
  parameter int          SIZE_LOG2 = 22,
  parameter logic [25:0] BASE      = 26'h0400000,
  parameter logic [7:0]  CART_ID   = 8'h5C,
  parameter int          TIMEOUT   = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE_R,
  input  logic [25:0]          AA,
  input  logic [15:0]          ADI,
  output logic [15:0]          ADO,
  input  logic                 ACS0_N,
  input  logic                 ACS1_N,
  input  logic                 ARD_N,
  input  logic                 AWRL_N,
  input  logic                 AWRU_N,
  output logic                 AWAIT_N,
  output logic [SIZE_LOG2-2:0] MEM_A,
  output logic [15:0]          MEM_D,
  input  logic [15:0]          MEM_Q,
  output logic [1:0]           MEM_BE,
  output logic                 MEM_WE,
  output logic                 MEM_REQ,
  input  logic                 MEM_ACK,
  output logic                 ERR
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_REQ  = 2'd1;
  localparam logic [1:0] S_WR_REQ  = 2'd2;
  localparam logic [1:0] S_RD_DONE = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]           state;
  logic                 rd_old;
  logic                 wr_old;
  logic                 buf_full;
  logic [SIZE_LOG2-2:0] buf_a;
  logic [15:0]          buf_d;
  logic [1:0]           buf_be;
  logic                 rd_pend;
  logic                 wr_stall;
  logic [SIZE_LOG2-2:0] rd_a;
  logic [CNT_W-1:0]     tmo_cnt;

  logic wr_low;
  logic rd_start;
  logic wr_start;
  logic ram_hit;
  logic id_hit;
  logic tmo_hit;
  logic wr_done;
  logic wr_take;
  logic cap_now;

  assign wr_low   = ~(AWRL_N & AWRU_N);
  assign rd_start = CE_R & ~ARD_N & rd_old;
  assign wr_start = CE_R & wr_low & wr_old;
  assign ram_hit  = ~ACS0_N & (AA[25:SIZE_LOG2] == BASE[25:SIZE_LOG2]);
  assign id_hit   = ~ACS1_N & (AA[23:0] == 24'hFFFFFE);
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // The posted write leaves the buffer this cycle, either acked or abandoned.
  assign wr_done  = (state == S_WR_REQ) & MEM_REQ & (MEM_ACK | tmo_hit);
  assign wr_take  = wr_start & ram_hit;
  // A new write lands in the buffer when it is empty or emptying right now;
  // a stalled write is captured from the still-held bus on the drain cycle.
  assign cap_now  = (wr_take & (~buf_full | wr_done)) | (wr_stall & wr_done);

  // Memory-side sequencing first, then bus-side events; later assignments
  // win so a buffer refill on the drain cycle overrides the clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      rd_old   <= 1'b1;
      wr_old   <= 1'b1;
      buf_full <= 1'b0;
      buf_a    <= '0;
      buf_d    <= '0;
      buf_be   <= '0;
      rd_pend  <= 1'b0;
      wr_stall <= 1'b0;
      rd_a     <= '0;
      tmo_cnt  <= '0;
      ADO      <= 16'hFFFF;
      AWAIT_N  <= 1'b1;
      MEM_REQ  <= 1'b0;
      MEM_WE   <= 1'b0;
      MEM_BE   <= 2'b00;
      MEM_A    <= '0;
      MEM_D    <= '0;
      ERR      <= 1'b0;
    end else begin
      if (CE_R) begin
        rd_old <= ARD_N;
        wr_old <= AWRL_N & AWRU_N;
      end

      case (state)
        // Posted write always goes first so a following read sees its data.
        S_IDLE: begin
          if (buf_full) begin
            MEM_REQ <= 1'b1;
            MEM_WE  <= 1'b1;
            MEM_A   <= buf_a;
            MEM_D   <= buf_d;
            MEM_BE  <= buf_be;
            tmo_cnt <= '0;
            state   <= S_WR_REQ;
          end else if (rd_pend) begin
            MEM_REQ <= 1'b1;
            MEM_WE  <= 1'b0;
            MEM_A   <= rd_a;
            MEM_BE  <= 2'b11;
            tmo_cnt <= '0;
            rd_pend <= 1'b0;
            state   <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (MEM_ACK) begin
            ADO     <= MEM_Q;
            AWAIT_N <= 1'b1;
            MEM_REQ <= 1'b0;
            state   <= S_RD_DONE;
          end else if (tmo_hit) begin
            ADO     <= 16'hFFFF;
            AWAIT_N <= 1'b1;
            MEM_REQ <= 1'b0;
            ERR     <= 1'b1;
            state   <= S_RD_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_WR_REQ: begin
          if (MEM_ACK || tmo_hit) begin
            MEM_REQ  <= 1'b0;
            buf_full <= 1'b0;
            state    <= S_IDLE;
            if (!MEM_ACK) begin
              ERR <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_RD_DONE: begin
          if (CE_R && ARD_N) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Bus side: write starts win over simultaneous read starts.
      if (cap_now) begin
        buf_full <= 1'b1;
        buf_a    <= AA[SIZE_LOG2-1:1];
        buf_d    <= ADI;
        buf_be   <= {~AWRU_N, ~AWRL_N};
        wr_stall <= 1'b0;
        if (wr_stall) begin
          AWAIT_N <= 1'b1;
        end
      end else if (wr_take) begin
        wr_stall <= 1'b1;
        AWAIT_N  <= 1'b0;
      end else if (rd_start && !wr_start) begin
        if (ram_hit) begin
          rd_pend <= 1'b1;
          rd_a    <= AA[SIZE_LOG2-1:1];
          AWAIT_N <= 1'b0;
        end else if (id_hit) begin
          ADO <= {8'hFF, CART_ID};
        end else begin
          ADO <= 16'hFFFF;
        end
      end
    end
  end

endmodule
